layer1_frame_sequencer: RTL

Frame-level controller placed in front of and behind the 8-channel first convolution layer (conv 3x3 + batch-norm + ReLU). It clears the layer between frames, streams exactly IMG_WIDTH*IMG_HEIGHT pixels from a ready/valid source into the layer, and counts the layer's output beats against the expected (IMG_WIDTH-2)*(IMG_HEIGHT-2). It flags the last output, signals frame completion, and reports timeout and overrun errors.

---
 rtl/layer1_frame_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/layer1_frame_sequencer.sv
// layer1_frame_sequencer
// Frame controller wrapped around the 8-channel first convolution layer.
// Each frame it clears the layer, streams IMG_WIDTH*IMG_HEIGHT pixels in,
// forwards (IMG_WIDTH-2)*(IMG_HEIGHT-2) result beats out, then pulses done.
// Extra or unexpected layer beats raise err_overrun. A stalled drain
// raises err_timeout.
module layer1_frame_sequencer #(
    parameter int unsigned DATA_WIDHT    = 32,
    parameter int unsigned IMG_WIDTH     = 220,
    parameter int unsigned IMG_HEIGHT    = 220,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err_timeout,
    output logic                    err_overrun,
    input  logic [DATA_WIDHT-1:0]   src_data,
    input  logic                    src_valid,
    output logic                    src_ready,
    output logic                    layer_rst,
    output logic [DATA_WIDHT-1:0]   layer_data,
    output logic                    layer_valid,
    input  logic [DATA_WIDHT*8-1:0] layer_dout,
    input  logic                    layer_vout,
    output logic [DATA_WIDHT*8-1:0] sink_data,
    output logic                    sink_valid,
    output logic                    sink_last
);

    localparam int unsigned N_IN  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned N_OUT = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
    localparam int unsigned CNT_W = $clog2(N_IN + 1);
    localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   in_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [CLR_W-1:0]   clr_cnt;
    logic [TO_W-1:0]    to_cnt;

    logic xfer;
    logic in_last;
    logic beat_ok;
    logic beat_last;

    // Handshake and beat qualification for the current cycle
    always_comb begin
        xfer      = src_valid && src_ready;
        in_last   = xfer && (in_cnt == CNT_W'(N_IN - 1));
        beat_ok   = layer_vout && ((state == FEED) || (state == DRAIN))
                    && (out_cnt != CNT_W'(N_OUT));
        beat_last = beat_ok && (out_cnt == CNT_W'(N_OUT - 1));
    end

    // Frame FSM with registered outputs, counters and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            src_ready   <= 1'b0;
            layer_rst   <= 1'b0;
            layer_data  <= '0;
            layer_valid <= 1'b0;
            sink_data   <= '0;
            sink_valid  <= 1'b0;
            sink_last   <= 1'b0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            clr_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            done        <= 1'b0;
            layer_valid <= 1'b0;
            sink_valid  <= 1'b0;
            sink_last   <= 1'b0;

            // Output side is evaluated in every state; beats outside the
            // frame window or beyond N_OUT are dropped and flagged.
            if (layer_vout) begin
                if (beat_ok) begin
                    sink_data  <= layer_dout;
                    sink_valid <= 1'b1;
                    sink_last  <= beat_last;
                    out_cnt    <= out_cnt + 1'b1;
                end else begin
                    err_overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    layer_rst <= 1'b1;
                    if (start) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        layer_rst   <= 1'b0;
                        err_timeout <= 1'b0;
                        err_overrun <= 1'b0;
                        in_cnt      <= '0;
                        out_cnt     <= '0;
                        to_cnt      <= '0;
                        clr_cnt     <= CLR_W'(CLR_CYCLES - 1);
                    end
                end
                CLEAR: begin
                    if (clr_cnt == '0) begin
                        state     <= FEED;
                        layer_rst <= 1'b1;
                        src_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                FEED: begin
                    if (xfer) begin
                        layer_data  <= src_data;
                        layer_valid <= 1'b1;
                        in_cnt      <= in_cnt + 1'b1;
                    end
                    // Final output beat takes priority over the final input.
                    if (beat_last) begin
                        state     <= DONE;
                        src_ready <= 1'b0;
                    end else if (in_last) begin
                        state     <= DRAIN;
                        src_ready <= 1'b0;
                        to_cnt    <= '0;
                    end
                end
                DRAIN: begin
                    if (beat_last) begin
                        state <= DONE;
                    end else if (layer_vout) begin
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_cnt == TO_W'(DRAIN_TIMEOUT - 1)) begin
                            err_timeout <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
